// File: rtl/memory_bank.sv
// memory_bank: parametrised single-port synchronous RAM with pipelined reads and a clear sequencer.
// Accesses are taken when cs is low and ready is high; reads return READ_LATENCY cycles later.
module memory_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int READ_LATENCY = 1,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cs,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  clear,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] o,
    output logic                  rd_valid,
    output logic                  err
);
    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_READY = 1'b1;
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic accept, in_range, last;
    logic s1_valid, s1_err;
    logic [DATA_WIDTH-1:0] s1_data;
    assign accept = ready && !cs;
    assign in_range = {1'b0, address} < LIMIT;
    assign last = cnt == LAST;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            cnt <= '0;
            ready <= 1'b0;
        end else if (state == ST_CLEAR) begin
            cnt <= last ? '0 : cnt + 1'b1;
            state <= last ? ST_READY : ST_CLEAR;
            ready <= last;
        end else begin
            state <= clear ? ST_CLEAR : ST_READY;
            ready <= !clear;
        end
    end
    // Array has no reset so it infers as block RAM; clearing is an ordinary sequenced write.
    always_ff @(posedge clock) begin
        if (state == ST_CLEAR) mem[cnt] <= CLEAR_VALUE;
        else if (accept && wr && in_range) mem[address] <= data;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_err <= 1'b0;
            s1_data <= '0;
        end else begin
            s1_valid <= accept && !wr;
            s1_err <= accept && !in_range;
            if (accept && !wr) s1_data <= in_range ? mem[address] : '0;
        end
    end
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    rd_valid <= 1'b0;
                    err <= 1'b0;
                    o <= '0;
                end else begin
                    rd_valid <= s1_valid;
                    err <= s1_err;
                    if (s1_valid) o <= s1_data;
                end
            end
        end else begin : g_lat1
            assign rd_valid = s1_valid;
            assign err = s1_err;
            assign o = s1_data;
        end
    endgenerate
endmodule

// File: doc/memory_bank.md
Name: memory_bank

Overview:
- Parametrised single-port synchronous RAM for the datapath; successor to the fixed 8x256 memory.
- Configurable width, depth and read latency; pipelined reads with valid strobe.
- Built-in clear sequencer fills every word with CLEAR_VALUE after reset or on demand; accesses stall (ready low) while clearing.
- Sits between the CPU/register-file datapath and the instruction/data address bus.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 8, address bus width.
- DEPTH, 256, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from accepted read to rd_valid; legal values 1 or 2.
- CLEAR_ON_RESET, 1, 1 = run the clear sequence after reset; 0 = go straight to READY.
- CLEAR_VALUE, 0, DATA_WIDTH-bit fill value.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- cs  input  1  chip select, active low; an access request.
- wr  input  1  0 = read, 1 = write.
- address  input  ADDR_WIDTH  word address.
- data  input  DATA_WIDTH  write data.
- clear  input  1  one-cycle request to refill memory with CLEAR_VALUE.
- ready  output  1  access accepted at a rising edge when ~cs && ready.
- o  output  DATA_WIDTH  read data; holds the last read value, never Z.
- rd_valid  output  1  one-cycle pulse when o carries new read data.
- err  output  1  one-cycle pulse, READ_LATENCY cycles after an out-of-range access (address >= DEPTH).

Behaviour:
- Reset (reset_n=0, asynchronous):
  - o=0, rd_valid=0, err=0, ready=0, clear counter=0.
  - Read pipeline flushed.
  - State = CLEAR if CLEAR_ON_RESET=1, else READY.
  - Memory contents are not altered by reset itself.
- FSM states: CLEAR, READY.
- CLEAR:
  - One word per cycle: mem[cnt] <= CLEAR_VALUE, cnt increments from 0 to DEPTH-1.
  - After writing DEPTH-1, go to READY and reset cnt to 0.
  - Takes exactly DEPTH cycles; ready=0 throughout; cs/wr ignored; clear input ignored.
- READY:
  - ready=1.
  - Accepted write: mem[address] <= data at that edge.
  - Accepted read: o updates and rd_valid=1 exactly READ_LATENCY cycles after the accepting edge.
  - Reads accepted every cycle are fully pipelined: one result per cycle, in order.
  - clear=1 in READY: next state CLEAR, ready drops at that edge. A simultaneous cs access in that cycle is still accepted (ready was 1).
  - Reads already in the pipeline complete normally during CLEAR. They return pre-clear data, since the read sampled the array at acceptance.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Out of range (address >= DEPTH):
  - Write: ignored.
  - Read: o=0 with rd_valid=1.
  - err pulses aligned with where rd_valid would be for that access (for writes, READ_LATENCY cycles after acceptance).
- When DEPTH = 2**ADDR_WIDTH, err never asserts.
- Reset mid-CLEAR restarts the sequence from address 0.
- No access: rd_valid=0, o holds.
- Array is inferable as block RAM: synchronous write, registered read.

Test Plan:
- Bench parameters: DATA_WIDTH=8, ADDR_WIDTH=4, DEPTH=12, READ_LATENCY=2, CLEAR_VALUE=8'hA5.
- Reset then release -> ready=0 for exactly 12 cycles, then 1. Read addresses 0..11 back-to-back -> 12 consecutive rd_valid pulses, each o=8'hA5, first pulse 2 cycles after first accept.
- Write 8'h3C to addr 5, then read addr 5 next cycle -> rd_valid and o=8'h3C 2 cycles later. Read addr 4 -> o=8'hA5.
- Write 8'h77 to addr 13 -> err pulse 2 cycles later. Read addr 13 -> o=8'h00, rd_valid=1, err=1. Read addr 5 -> still 8'h3C.
- Read addr 5 with clear=1 in the same cycle -> read returns 8'h3C, ready low 12 cycles. Afterwards read addr 5 -> 8'hA5.
- Assert reset_n=0 at clear cycle 6, release -> full 12-cycle clear restarts from addr 0. o=0 and rd_valid=0 during reset.
- CLEAR_ON_RESET=0 build -> ready=1 on the first edge after reset release. Writes and reads are accepted immediately, no clear writes.
